// File: rtl/imem_responder.sv
// Instruction ROM responder: accepts fetches over req/addr_ok, returns words in order after LATENCY cycles.
// Optional build macro IMEM_RAND_STALL_EN adds LFSR-driven accept stalls.
module imem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2,
  parameter int MAX_OUT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [31:0]           addr,
  output logic                  addr_ok,
  output logic                  data_ok,
  output logic [31:0]           rdata,
  output logic                  err,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_idx,
  input  logic [31:0]           load_data
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam int          CNT_W     = $clog2(MAX_OUT + 1);
  localparam int          SH        = DEPTH_LOG2 + 2;
  localparam logic [31:0] BOOT_PHYS = 32'h1FC0_0000;

  // The ROM answers in the low physical window and in the reset-vector window at 0x1FC0_0000.
  function automatic logic fetch_bad(input logic [31:0] phys, input logic [1:0] low);
    logic [31:0] hi;
    hi = phys >> SH;
    return (low != 2'b00) || !((hi == 32'd0) || (hi == (BOOT_PHYS >> SH)));
  endfunction

  logic [31:0]           mem [DEPTH];
  logic [31:0]           phys;
  logic [DEPTH_LOG2-1:0] fetch_idx;
  logic                  bad;
  logic                  stall;
  logic                  accept;
  logic [CNT_W-1:0]      count;
  logic                  err_q;
  logic [LATENCY-1:0]    vld_p;
  logic [31:0]           data_p [LATENCY];

  assign phys      = addr & 32'h1FFF_FFFF;
  assign fetch_idx = phys[DEPTH_LOG2+1:2];
  assign bad       = fetch_bad(phys, addr[1:0]);

`ifdef IMEM_RAND_STALL_EN
  logic [7:0] lfsr;
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  assign addr_ok = !rst && !stall && (count < CNT_W'(MAX_OUT));
  assign accept  = req && addr_ok;
  assign data_ok = !rst && vld_p[LATENCY-1];
  assign rdata   = rst ? 32'h0 : data_p[LATENCY-1];
  assign err     = !rst && err_q;

  // Preload port; the fetch read below sees the pre-write word in a same-edge collision.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_data;
  end

  // Control: valid shift chain, in-flight count, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
      case ({accept, data_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (accept && bad) err_q <= 1'b1;
    end
  end

  // Data: p0 samples the array on accept; later stages advance only behind a valid so rdata holds.
  always_ff @(posedge clk) begin
    if (accept) data_p[0] <= bad ? 32'h0 : mem[fetch_idx];
    for (int i = 1; i < LATENCY; i++) begin
      if (vld_p[i-1]) data_p[i] <= data_p[i-1];
    end
    if (rst) data_p[LATENCY-1] <= 32'h0;
  end

endmodule
